// File: rtl/bus_master_if_pkg.sv
// Shared bus encodings and the bus_master_if state encoding.
// The active-low level names keep the bus polarity explicit at each use.
package bus_master_if_pkg;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;

  localparam int BUS_IF_STATE_W = 2;

  typedef enum logic [BUS_IF_STATE_W-1:0] {
    BUS_IF_STATE_IDLE   = 2'd0,
    BUS_IF_STATE_REQ    = 2'd1,
    BUS_IF_STATE_ACCESS = 2'd2,
    BUS_IF_STATE_DONE   = 2'd3
  } bus_if_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Per-master bus front-end: turns a core access into req/grant/strobe/ready
// handshakes on the shared bus, with an access watchdog and a pre-grant flush.
//
// state  | meaning
// IDLE   | no access; accepts core_req unless core_flush
// REQ    | bus_req_n low, waiting for grant (flush cancels)
// ACCESS | strobe issued, waiting for bus_rdy_n or watchdog expiry
// DONE   | result valid to core; held while core_stall
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  input  logic              core_stall,
  input  logic              core_flush,
  output logic              core_busy,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              core_err,
  output logic              bus_req_n,
  input  logic              bus_grnt_n,
  output logic              bus_as_n,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_n
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  bus_if_state_e     state_q, state_nxt;
  logic [WD_W-1:0]   wd_q, wd_nxt;
  logic              req_n_nxt, as_n_nxt, rw_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt, rd_data_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= BUS_IF_STATE_IDLE;
      wd_q         <= '0;
      bus_req_n    <= DISABLE_;
      bus_as_n     <= DISABLE_;
      bus_rw       <= READ;
      bus_addr     <= '0;
      bus_wr_data  <= '0;
      core_rd_data <= '0;
      core_err     <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      wd_q         <= wd_nxt;
      bus_req_n    <= req_n_nxt;
      bus_as_n     <= as_n_nxt;
      bus_rw       <= rw_nxt;
      bus_addr     <= addr_nxt;
      bus_wr_data  <= wr_data_nxt;
      core_rd_data <= rd_data_nxt;
      core_err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    wd_nxt      = wd_q;
    req_n_nxt   = bus_req_n;
    as_n_nxt    = bus_as_n;
    rw_nxt      = bus_rw;
    addr_nxt    = bus_addr;
    wr_data_nxt = bus_wr_data;
    rd_data_nxt = core_rd_data;
    err_nxt     = core_err;

    unique case (state_q)
      BUS_IF_STATE_IDLE: begin
        if (core_req && !core_flush) begin
          rw_nxt      = core_rw;
          addr_nxt    = core_addr;
          wr_data_nxt = core_wr_data;
          req_n_nxt   = ENABLE_;
          err_nxt     = 1'b0;
          state_nxt   = BUS_IF_STATE_REQ;
        end
      end
      BUS_IF_STATE_REQ: begin
        // flush wins over a simultaneous grant so no strobe escapes
        if (core_flush) begin
          req_n_nxt = DISABLE_;
          state_nxt = BUS_IF_STATE_IDLE;
        end else if (bus_grnt_n == ENABLE_) begin
          as_n_nxt  = ENABLE_;
          wd_nxt    = '0;
          state_nxt = BUS_IF_STATE_ACCESS;
        end
      end
      BUS_IF_STATE_ACCESS: begin
        as_n_nxt = DISABLE_;
        if (bus_rdy_n == ENABLE_) begin
          req_n_nxt = DISABLE_;
          if (bus_rw == READ) rd_data_nxt = bus_rd_data;
          state_nxt = BUS_IF_STATE_DONE;
        end else if (wd_q == WD_LAST) begin
          req_n_nxt = DISABLE_;
          err_nxt   = 1'b1;
          state_nxt = BUS_IF_STATE_DONE;
        end else begin
          wd_nxt = wd_q + 1'b1;
        end
      end
      BUS_IF_STATE_DONE: begin
        if (!core_stall) state_nxt = BUS_IF_STATE_IDLE;
      end
      default: state_nxt = BUS_IF_STATE_IDLE;
    endcase
  end

  assign core_busy = ((state_q == BUS_IF_STATE_IDLE) && core_req && !core_flush)
                   || (state_q == BUS_IF_STATE_REQ)
                   || (state_q == BUS_IF_STATE_ACCESS);

endmodule
